// File: rtl/sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package sweep_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  // Cycles each minterm is held before it is sampled (legal 1..15).
  localparam int SETTLE_DEFAULT = 2;

  // Expected F per minterm, bit i = F(i): minterms 2,3,4,6,7.
  localparam logic [7:0] TRUTH_DEFAULT = 8'hDC;

  // Highest minterm index of a 3-input function.
  localparam logic [2:0] LAST_MINTERM = 3'd7;

  // Expected output bit for one minterm of a truth table.
  function automatic logic truth_bit(input logic [7:0] truth, input logic [2:0] idx);
    return truth[idx];
  endfunction

endpackage

// File: rtl/mismatch_detect.sv
// Per-minterm comparator: flags when any of the three implementations
// disagrees with the expected value.
module mismatch_detect (
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic expected,
  output logic any_mismatch
);

  // One flag per minterm, however many of f/g/h are wrong.
  assign any_mismatch = (f ^ expected) | (g ^ expected) | (h ^ expected);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 8 minterms of {x,y,z}, holds each for SETTLE cycles, then
// samples f/g/h against TRUTH and accumulates a mismatch count and mask.
//
// Handshake: start is a level request, sampled only in IDLE; busy is high
// from the cycle after acceptance until DONE; done is a one-cycle pulse in
// DONE; err_count/fail_mask/pass hold until the next accepted start or rst.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int         SETTLE = SETTLE_DEFAULT,
  parameter logic [7:0] TRUTH  = TRUTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         x,
  output logic         y,
  output logic         z,
  input  logic         f,
  input  logic         g,
  input  logic         h,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   err_count,
  output logic [7:0]   fail_mask,
  output sweep_state_e dbg_state
);

  // Settle counter runs 0..SETTLE-1 while a minterm is being driven.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  sweep_state_e state_q;
  logic [2:0]   idx_q;
  logic [3:0]   cnt_q;
  logic [2:0]   xyz_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;
  logic [3:0]   err_q;
  logic [7:0]   mask_q;

  logic         expected_bit;
  logic         mism;
  logic [3:0]   err_d;
  logic [7:0]   mask_d;

  assign expected_bit = truth_bit(TRUTH, idx_q);

  mismatch_detect u_mismatch_detect (
    .f            (f),
    .g            (g),
    .h            (h),
    .expected     (expected_bit),
    .any_mismatch (mism)
  );

  // Result values as they would be after sampling the current minterm.
  always_comb begin
    err_d  = err_q + {3'b000, mism};
    mask_d = mask_q;
    if (mism) begin
      mask_d = mask_q | (8'b0000_0001 << idx_q);
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      xyz_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      mask_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          xyz_q  <= 3'd0;
          if (start) begin
            err_q   <= 4'd0;
            mask_q  <= 8'd0;
            pass_q  <= 1'b0;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= 4'd0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_SAMPLE: begin
          err_q  <= err_d;
          mask_q <= mask_d;
          if (idx_q == LAST_MINTERM) begin
            // Pass must include the verdict of the final minterm.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            xyz_q   <= idx_q + 3'd1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          xyz_q   <= 3'd0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign x         = xyz_q[2];
  assign y         = xyz_q[1];
  assign z         = xyz_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: an abstract timing/result
// model checked every cycle for the SETTLE=2 instance, plus literal checks
// for each scenario and a SETTLE=1 instance.
module tb_truth_table_sweeper;
  import sweep_pkg::*;

  localparam int S0 = 2;
  localparam int L0 = 8 * (S0 + 1);  // cycles of drive+sample per sweep

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT 0: SETTLE=2 ----------------
  logic         start;
  logic         x, y, z, f, g, h;
  logic         busy, done, pass;
  logic [3:0]   err_count;
  logic [7:0]   fail_mask;
  sweep_state_e dbg_state;

  // ---------------- DUT 1: SETTLE=1 ----------------
  logic         start1;
  logic         x1, y1, z1, f1, g1, h1;
  logic         busy1, done1, pass1;
  logic [3:0]   err_count1;
  logic [7:0]   fail_mask1;
  sweep_state_e dbg_state1;

  truth_table_sweeper #(.SETTLE(S0), .TRUTH(8'hDC)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z),
    .f(f), .g(g), .h(h), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.SETTLE(1), .TRUTH(8'hDC)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .z(z1),
    .f(f1), .g(g1), .h(h1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_mask(fail_mask1), .dbg_state(dbg_state1)
  );

  // ---------------- functions under test ----------------
  // fault_mode: 0 = all correct, 1 = h stuck-at-0, 2 = g inverted at minterm 5
  logic [7:0] truth_exp = 8'hDC;
  int         fault_mode = 0;

  function automatic logic [2:0] fgh_for(input int mode, input int i);
    logic fv;
    logic gv;
    logic hv;
    fv = truth_exp[i];
    gv = (mode == 2 && i == 5) ? ~fv : fv;
    hv = (mode == 1) ? 1'b0 : fv;
    return {fv, gv, hv};
  endfunction

  assign {f, g, h}    = fgh_for(fault_mode, int'({x, y, z}));
  assign {f1, g1, h1} = {3{truth_exp[{x1, y1, z1}]}};

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // p = cycles since the accept edge (0 = idle); 1..L0 sweeping, L0+1 = done.
  int         p = 0;
  logic [3:0] r_err  = 4'd0;
  logic [7:0] r_mask = 8'd0;
  logic       r_pass = 1'b0;
  logic       model_on = 1'b0;

  function automatic logic mism(input int i);
    return fgh_for(fault_mode, i) != {3{truth_exp[i]}};
  endfunction

  function automatic logic [3:0] err_first(input int n);
    logic [3:0] c;
    c = 4'd0;
    for (int j = 0; j < n; j++) if (mism(j)) c = c + 4'd1;
    return c;
  endfunction

  function automatic logic [7:0] mask_first(input int n);
    logic [7:0] m;
    m = 8'd0;
    for (int j = 0; j < n; j++) if (mism(j)) m[j] = 1'b1;
    return m;
  endfunction

  function automatic int next_p(input int cur, input logic r, input logic s);
    if (r)              return 0;
    if (cur == 0)       return s ? 1 : 0;
    if (cur == L0 + 1)  return 0;
    return cur + 1;
  endfunction

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    p <= next_p(p, rst, start);
    if (!rst && next_p(p, rst, start) == L0 + 1) begin
      r_err  <= err_first(8);
      r_mask <= mask_first(8);
      r_pass <= (err_first(8) == 4'd0);
    end else if (rst || (p == 0 && start)) begin
      r_err  <= 4'd0;
      r_mask <= 8'd0;
      r_pass <= 1'b0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", 32'(busy), 32'(p >= 1 && p <= L0));
      chk("done", 32'(done), 32'(p == L0 + 1));
      if (p <= L0)
        chk("xyz", 32'({x, y, z}), (p == 0) ? 0 : (p - 1) / (S0 + 1));
      if (p >= 1 && p <= L0) begin
        chk("err_count_run", 32'(err_count), 32'(err_first((p - 1) / (S0 + 1))));
        chk("fail_mask_run", 32'(fail_mask), 32'(mask_first((p - 1) / (S0 + 1))));
      end else begin
        chk("err_count", 32'(err_count), 32'(r_err));
        chk("fail_mask", 32'(fail_mask), 32'(r_mask));
      end
      chk("pass", 32'(pass), 32'(r_pass));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) start = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    if (which == 0) start = 1'b0; else start1 = 1'b0;
  endtask

  // Called right after pulse_start: returns edges from accept to done rising.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int seen;
  int d_cyc[$];

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    model_on = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xyz", 32'({x, y, z}), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_mask", 32'(fail_mask), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_state1", 32'(dbg_state1), 32'(ST_IDLE));

    // Correct implementations: done 24 edges after accept, clean result
    fault_mode = 0;
    pulse_start(0);
    wait_done(lat);
    chk("ok_latency", 32'(lat), 32'd24);
    chk("ok_pass", 32'(pass), 32'd1);
    chk("ok_err", 32'(err_count), 32'd0);
    chk("ok_mask", 32'(fail_mask), 32'h00);
    idle_cycles(3);

    // h stuck-at-0: every F=1 minterm fails
    fault_mode = 1;
    pulse_start(0);
    wait_done(lat);
    chk("h0_pass", 32'(pass), 32'd0);
    chk("h0_err", 32'(err_count), 32'd5);
    chk("h0_mask", 32'(fail_mask), 32'hDC);
    idle_cycles(4);
    chk("h0_hold_err", 32'(err_count), 32'd5);

    // g inverted only at minterm 5
    fault_mode = 2;
    pulse_start(0);
    wait_done(lat);
    chk("g5_pass", 32'(pass), 32'd0);
    chk("g5_err", 32'(err_count), 32'd1);
    chk("g5_mask", 32'(fail_mask), 32'h20);
    idle_cycles(3);

    // Reset while minterm 4 is driven (h stuck so partial results are nonzero)
    fault_mode = 1;
    pulse_start(0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ({x, y, z} == 3'd4) begin seen = 1; break; end
    end
    chk("abort_reached_idx4", 32'(seen), 32'd1);
    chk("abort_pre_err", 32'(err_count), 32'd2);
    chk("abort_pre_mask", 32'(fail_mask), 32'h0C);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_xyz", 32'({x, y, z}), 32'd0);
    chk("abort_err", 32'(err_count), 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    fault_mode = 0;
    pulse_start(0);
    wait_done(lat);
    chk("after_abort_latency", 32'(lat), 32'd24);
    chk("after_abort_pass", 32'(pass), 32'd1);
    idle_cycles(3);

    // Start toggling during busy must not disturb the sweep
    pulse_start(0);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin lat = k - 1; break; end
      if (k <= 20) begin
        @(posedge clk); #1 start = (k % 2 == 1);
      end
    end
    chk("toggle_latency", 32'(lat), 32'd24);
    idle_cycles(3);

    // Start held for 60 cycles: the first observed cycle is still idle
    // (accept happens on the following edge), so done lands at 25 and 51.
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) d_cyc.push_back(c);
    end
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_count", 32'(d_cyc.size()), 32'd2);
    if (d_cyc.size() == 2) begin
      chk("b2b_first", 32'(d_cyc[0]), 32'd25);
      chk("b2b_gap", 32'(d_cyc[1] - d_cyc[0] - 1), 32'd25);
    end
    idle_cycles(30);

    // SETTLE=1 instance: minterm steps every 2 cycles, done 16 after accept
    pulse_start(1);
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      chk("s1_xyz", 32'({x1, y1, z1}), 32'((m - 1) / 2));
      chk("s1_busy", 32'(busy1), 32'd1);
      chk("s1_done_early", 32'(done1), 32'd0);
    end
    @(negedge clk);
    chk("s1_done", 32'(done1), 32'd1);
    chk("s1_pass", 32'(pass1), 32'd1);
    chk("s1_err", 32'(err_count1), 32'd0);
    chk("s1_mask", 32'(fail_mask1), 32'h00);
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the number of cycles each input combination is held before sampling (legal range 1..15).
REQ-002 SHALL have parameter TRUTH, default 8'hDC, meaning the expected output per minterm, with bit i = F(i) (minterms 2,3,4,6,7).
REQ-003 SHALL have port clk  input  1  system clock; the only clock, and all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one full 8-minterm sweep; sampled only in IDLE.
REQ-006 SHALL have ports x, y, z  output  1 each  registered stimulus to the function under test; {x,y,z} = minterm index, with x as MSB.
REQ-007 SHALL have ports f, g, h  input  1 each  the three implementations under test (reference, NOR-only, NAND-only).
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until DONE is reached.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 SHALL have port err_count  output  4  number of mismatching minterms (0..8).
REQ-012 SHALL have port fail_mask  output  8  bit i is set if minterm i mismatched on any of f, g, h.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 In IDLE, start=1 SHALL clear err_count/fail_mask/pass, set idx=0 and settle counter=0, and enter DRIVE.
REQ-015 DRIVE SHALL hold {x,y,z}=idx for exactly SETTLE cycles, then enter SAMPLE.
REQ-016 SAMPLE (one cycle) SHALL compare each of f, g, h against TRUTH[idx]; on any mismatch it SHALL set fail_mask[idx] and increment err_count by 1 (once per minterm, not once per output).
REQ-017 After SAMPLE with idx<7, the block SHALL increment idx and return to DRIVE; after SAMPLE with idx=7 it SHALL enter DONE (no idx wrap).
REQ-018 DONE SHALL last one cycle: done=1, busy=0, pass=(err_count==0 including the final sample); next state IDLE.
REQ-019 Sweep latency SHALL be fixed: done is high exactly 8*(SETTLE+1) cycles after the start-accept edge (24 at SETTLE=2).
REQ-020 start SHALL be ignored in DRIVE, SAMPLE and DONE; start held high SHALL launch back-to-back sweeps with one IDLE cycle between them.
REQ-021 x, y, z SHALL return to 0 in IDLE; err_count, fail_mask and pass SHALL hold their values until the next accepted start or rst.

Reset
REQ-022 rst=1 SHALL, at the next clock edge, force IDLE and drive x=y=z=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, idx=0, settle counter=0.
REQ-023 rst asserted mid-sweep SHALL abort the sweep without asserting done; rst SHALL take priority over a simultaneous start.

Structure
REQ-024 State encoding, the TRUTH default (8'hDC) and the SETTLE default SHALL live in the shared package sweep_pkg.
REQ-025 The per-minterm compare SHALL be one combinational sub-module, mismatch_detect (inputs f, g, h, expected; output any_mismatch); the counters and FSM SHALL stay in truth_table_sweeper.

Verification
REQ-026 Bench SHALL cover: correct DUT (f=g=h=F), SETTLE=2, one start pulse -> done 24 cycles later, pass=1, err_count=0, fail_mask=8'h00.
REQ-027 Bench SHALL cover: h stuck-at-0 -> err_count=5, fail_mask=8'hDC, pass=0.
REQ-028 Bench SHALL cover: g inverted only at minterm 5 -> err_count=1, fail_mask=8'h20, pass=0.
REQ-029 Bench SHALL cover: rst pulsed while idx=4 -> next cycle busy=0, {x,y,z}=0, err_count=0, no done; a following start completes normally with pass=1.
REQ-030 Bench SHALL cover: start held high for 60 cycles -> exactly two done pulses, 25 cycles apart; extra start edges during busy have no effect.
REQ-031 Bench SHALL cover: SETTLE=1 -> {x,y,z} steps 0..7 every 2 cycles; done 16 cycles after start accept.
